// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 LSB-first UART receiver feeding the NMEA parser.
// Optional build macro: GPS_UART_RX_MAJORITY_EN (2-of-3 bit voting).
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idles high
//   po_data    out  [7:0] last correctly received byte
//   po_flag    out  one-cycle strobe, po_data is new
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   rx_busy    out  high while a frame is in progress
module gps_uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_CNT_MAX = CLK_FREQ / BAUD;
    localparam int HALF        = BIT_CNT_MAX / 2;
    localparam int CW          = $clog2(BIT_CNT_MAX);

`ifdef GPS_UART_RX_MAJORITY_EN
    // Vote completes one count later than the centre sample.
    localparam int DEC = HALF + 1;
`else
    localparam int DEC = HALF;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_s1_q, rx_s2_q, rx_h_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_run;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          flag_q, flag_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          start_edge;
    logic          at_dec;
    logic          bit_val;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_h_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_h_q  <= rx_s2_q;
        end
    end

    assign start_edge = rx_h_q & ~rx_s2_q;
    assign at_dec     = (cnt_q == CNT_DEC);

`ifdef GPS_UART_RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;

    // Capture the two early samples; the third is the live line.
    always_comb begin
        maj_d = maj_q;
        if (cnt_q == CW'(HALF - 1)) begin
            maj_d[0] = rx_s2_q;
        end
        if (cnt_q == CW'(HALF)) begin
            maj_d[1] = rx_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end

    assign bit_val = (maj_q[0] & maj_q[1])
                   | (maj_q[0] & rx_s2_q)
                   | (maj_q[1] & rx_s2_q);
`else
    assign bit_val = rx_s2_q;
`endif

    assign cnt_run = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = S_START;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                end
            end

            // Confirm the start bit mid-period, then wait out the
            // rest of it so data samples land mid-bit.
            S_START: begin
                cnt_d = cnt_run;
                if (at_dec && bit_val) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                cnt_d = cnt_run;
                if (at_dec) begin
                    shift_d[idx_q] = bit_val;
                end
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            // Leave mid stop bit so a back-to-back start is caught.
            S_STOP: begin
                cnt_d = cnt_run;
                if (at_dec) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        data_d  = shift_q;
                        flag_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                cnt_d = '0;
                if (rx_s2_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign po_data   = data_q;
    assign po_flag   = flag_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: directed and random frames for gps_uart_rx.
// Expected bytes come from a queue-based line model.
module tb_gps_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BITC     = CLK_FREQ / BAUD;
    localparam int HALF     = BITC / 2;
`ifdef GPS_UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    localparam int LAT = 2 + 9 * BITC + HALF + 1 + (MAJ ? 1 : 0);

    logic       sys_clk;
    logic       sys_rst_n;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    gps_uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx       (rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [7:0] got[$];
    int         n_ferr    = 0;
    int         n_overlap = 0;
    int         n_long    = 0;
    logic       prev_flag = 1'b0;
    logic       prev_ferr = 1'b0;
    time        t_flag    = 0;
    time        t_fall    = 0;

    // Monitor: record every strobe, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (po_flag) begin
            got.push_back(po_data);
            t_flag = $time;
        end
        if (frame_err) n_ferr++;
        if (po_flag && frame_err) n_overlap++;
        if ((po_flag && prev_flag) || (frame_err && prev_ferr)) n_long++;
        prev_flag = po_flag;
        prev_ferr = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    // glitch_bit < 0 means no glitch; stop selects stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input int glitch_bit);
        rx = 1'b0;
        t_fall = $time;
        repeat (BITC) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                repeat (HALF + 1) @(negedge sys_clk);
                rx = ~b[i];
                @(negedge sys_clk);
                rx = b[i];
                repeat (BITC - HALF - 2) @(negedge sys_clk);
            end else begin
                repeat (BITC) @(negedge sys_clk);
            end
        end
        rx = stop;
        repeat (BITC) @(negedge sys_clk);
    endtask

    task automatic expect_bytes(input string tag, input int base,
                                input logic [7:0] exp_q[$]);
        check({tag, "_count"}, got.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < got.size())
                check($sformatf("%s_byte%0d", tag, i), got[base + i], exp_q[i]);
            else
                check($sformatf("%s_byte%0d", tag, i), 32'hXXXX, exp_q[i]);
        end
    endtask

    initial begin
        int         base;
        int         fbase;
        int         lat;
        int         waited;
        logic [7:0] last_data;
        logic [7:0] exp_q[$];
        logic [7:0] nmea[6];
        logic [7:0] b;
        logic [7:0] gexp;

        sys_rst_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("rst_po_data", po_data, 8'h00);
        check("rst_po_flag", po_flag, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        sys_rst_n = 1'b1;
        idle(10);
        last_data = 8'h00;

        // Single '$' frame
        base = got.size();
        fbase = n_ferr;
        send_byte(8'h24, 1'b1, -1);
        idle(5);
        exp_q = '{8'h24};
        expect_bytes("dollar", base, exp_q);
        last_data = 8'h24;
        check("dollar_ferr", n_ferr - fbase, 0);
        check("dollar_busy", rx_busy, 1'b0);
        lat = int'((t_flag - t_fall) / 10);
        check("dollar_latency",
              (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);

        // 3-clock glitch on idle line
        base = got.size();
        fbase = n_ferr;
        rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        rx = 1'b1;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            waited++;
            if (!rx_busy) break;
        end
        check("glitch_busy_low", rx_busy, 1'b0);
        idle(40);
        check("glitch_flags", got.size() - base, 0);
        check("glitch_ferr", n_ferr - fbase, 0);

        // Framing error, held break, then recovery
        base = got.size();
        fbase = n_ferr;
        send_byte(8'h41, 1'b0, -1);
        rx = 1'b0;
        repeat (40) @(negedge sys_clk);
        idle(20);
        check("ferr_count", n_ferr - fbase, 1);
        check("ferr_no_flag", got.size() - base, 0);
        check("ferr_po_data", po_data, last_data);
        send_byte(8'h2A, 1'b1, -1);
        idle(5);
        exp_q = '{8'h2A};
        expect_bytes("after_ferr", base, exp_q);
        last_data = 8'h2A;
        check("after_ferr_ferr", n_ferr - fbase, 1);

        // Back-to-back "$GNRMC"
        nmea = '{8'h24, 8'h47, 8'h4E, 8'h52, 8'h4D, 8'h43};
        base = got.size();
        exp_q = {};
        foreach (nmea[i]) begin
            send_byte(nmea[i], 1'b1, -1);
            exp_q.push_back(nmea[i]);
        end
        idle(10);
        expect_bytes("gnrmc", base, exp_q);
        last_data = 8'h43;

        // Reset during bit 4 of 0x55
        base = got.size();
        b = 8'h55;
        rx = 1'b0;
        repeat (BITC) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge sys_clk);
        end
        rx = b[4];
        repeat (HALF) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rx = 1'b1;
        @(negedge sys_clk);
        check("midrst_po_data", po_data, 8'h00);
        check("midrst_busy", rx_busy, 1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(20);
        send_byte(8'hA5, 1'b1, -1);
        idle(5);
        exp_q = '{8'hA5};
        expect_bytes("midrst", base, exp_q);
        last_data = 8'hA5;

        // One-clock glitch at the centre of bit 2 of 0x0F
        base = got.size();
        b = 8'h0F;
        gexp = b;
        if (!MAJ) gexp[2] = ~gexp[2];
        send_byte(b, 1'b1, 2);
        idle(5);
        exp_q = '{gexp};
        expect_bytes("vote", base, exp_q);
        check("vote_po_data", po_data, gexp);

        // Random bytes with random gaps, some back-to-back
        base = got.size();
        fbase = n_ferr;
        exp_q = {};
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, -1);
            exp_q.push_back(b);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 30));
        end
        idle(10);
        expect_bytes("random", base, exp_q);
        check("random_ferr", n_ferr - fbase, 0);

        check("strobe_overlap", n_overlap, 0);
        check("strobe_width", n_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gps_uart_rx.md
Name: gps_uart_rx

Overview:
- UART receiver (8N1, LSB first) for the GPS module serial line.
- Sits directly upstream of the NMEA sentence parser and produces its byte stream: po_data[7:0] plus a one-cycle po_flag strobe per valid byte.
- Also reports framing errors and a busy indication for debug/LED use.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BIT_CNT_MAX (derived localparam), CLK_FREQ/BAUD, clocks per bit. Must be >= 8; HALF = BIT_CNT_MAX/2.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- rx  input  1  asynchronous serial line from GPS; idles high
- po_data  output  8  last correctly received byte
- po_flag  output  1  one-cycle strobe: po_data is new and valid
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- rx_busy  output  1  high while a frame is in progress

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low; clock is sys_clk.
  - Outputs: po_data=0, po_flag=0, frame_err=0, rx_busy=0.
  - Synchroniser flops are set to 1; FSM goes to IDLE; all counters are 0.
- Input conditioning: rx passes through a 2-flop synchroniser plus one history flop. A start edge is synchronised-high followed by synchronised-low.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on start edge, go to START, clear bit counter, set rx_busy=1.
  - START: baud counter counts 0..BIT_CNT_MAX-1. At count HALF, sample the line.
    - Line high: false start. Go to IDLE, rx_busy=0, no strobe.
    - Line low: restart the counter and go to DATA.
  - DATA: sample at HALF of each bit period. Shift into bit[idx], idx 0..7, LSB first. After bit 7's period completes, go to STOP.
  - STOP: sample at HALF.
    - High: po_data <= shift register and po_flag=1 for exactly one cycle (the cycle after the sample). Go to IDLE immediately, without waiting out the remaining half bit, so a back-to-back start edge is caught.
    - Low: frame_err=1 for one cycle, po_data unchanged, go to BREAK.
  - BREAK: stay until the synchronised line is high, then go to IDLE. rx_busy stays 1 in BREAK.
- Latency: po_flag rises (2 sync cycles) + 9*BIT_CNT_MAX + HALF + 1 clocks after the rx falling edge, ±1 cycle.
- po_flag and frame_err are never high in the same cycle. Neither is ever high for more than one cycle.
- Baud counter rolls back to 0 at BIT_CNT_MAX-1. It never wraps otherwise.
- Line activity in IDLE other than a start edge is ignored.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded, with no strobe.

Optional Feature:
- Macro: GPS_UART_RX_MAJORITY_EN.
- Defined: each bit (start, data, stop) is sampled at counts HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, decided at HALF+1. All "at HALF" decision points move to HALF+1, so latency grows by 1 clock.
- Undefined: single sample at HALF, exactly as above.

Test Plan:
(bench parameters: CLK_FREQ=1_600_000, BAUD=100_000 → BIT_CNT_MAX=16)
- Idle line high, then frame 0x24 ('$') -> exactly one po_flag pulse with po_data=8'h24; frame_err stays 0; rx_busy low after the pulse.
- 3-clock low glitch on idle line -> START rejects it at HALF; no po_flag, no frame_err; rx_busy back to 0 within 10 clocks.
- Frame 0x41 with stop bit low, line held low 40 clocks, then high, then frame 0x2A -> one frame_err pulse, po_data stays at its prior value; then po_flag with po_data=8'h2A.
- "$GNRMC" sent back-to-back with zero idle between stop and next start -> 6 po_flag pulses with 24,47,4E,52,4D,43 in order, none dropped.
- Reset pulsed during bit 4 of frame 0x55, released, then frame 0xA5 sent -> no strobe for 0x55; po_data=8'hA5 with one po_flag.
- Macro defined: frame 0x0F with a 1-clock inverted glitch exactly at HALF of bit 2 -> po_data=8'h0F. Macro undefined, same stimulus -> po_data=8'h0B.
